// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg
//   Shared definitions for the RV32M multiply/divide unit.
//   - MULDIV_* : funct3 (Instr[14:12]) encodings of the eight M-extension ops.
//   - Helper functions that classify an op:
//     - is it a divide?
//     - is operand A signed?
//     - is operand B signed?
package muldiv_unit_pkg;

  localparam logic [2:0] MULDIV_MUL    = 3'b000;
  localparam logic [2:0] MULDIV_MULH   = 3'b001;
  localparam logic [2:0] MULDIV_MULHSU = 3'b010;
  localparam logic [2:0] MULDIV_MULHU  = 3'b011;
  localparam logic [2:0] MULDIV_DIV    = 3'b100;
  localparam logic [2:0] MULDIV_DIVU   = 3'b101;
  localparam logic [2:0] MULDIV_REM    = 3'b110;
  localparam logic [2:0] MULDIV_REMU   = 3'b111;

  // funct3[2] separates the divide/remainder group from the multiply group.
  function automatic logic op_is_div(input logic [2:0] f);
    return f[2];
  endfunction

  // Operand A (multiplicand / dividend) is signed for MUL, MULH, MULHSU, DIV and REM.
  function automatic logic op_a_signed(input logic [2:0] f);
    return (f == MULDIV_MUL) || (f == MULDIV_MULH) || (f == MULDIV_MULHSU) ||
           (f == MULDIV_DIV) || (f == MULDIV_REM);
  endfunction

  // Operand B (multiplier / divisor) is signed for MUL, MULH, DIV and REM.
  function automatic logic op_b_signed(input logic [2:0] f);
    return (f == MULDIV_MUL) || (f == MULDIV_MULH) ||
           (f == MULDIV_DIV) || (f == MULDIV_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative RV32M multiply/divide unit.
//   - One radix-2 step is performed per clock, DATA_WIDTH steps in total.
//   - One extra clock applies the sign correction and registers the result.
//   - Every op has the same fixed latency.
//
// Ports
//   clk       in   1           clock
//   rst       in   1           synchronous active-high reset
//   start     in   1           request, accepted in IDLE or DONE
//   kill      in   1           abort in-flight op (pipeline flush)
//   funct3    in   3           op select, sampled with start
//   rs1_data  in   DATA_WIDTH  operand A (multiplicand / dividend)
//   rs2_data  in   DATA_WIDTH  operand B (multiplier / divisor)
//   busy      out  1           op in flight
//   done      out  1           one-cycle result-valid pulse
//   result    out  DATA_WIDTH  registered result, held until the next op completes
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  kill,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   count_reg;
  logic [2:0]      op_reg;
  // Mul: {partial product high, multiplier shifting out}.
  // Div: {partial remainder, dividend shifting in quotient bits}.
  logic [2*W-1:0]  acc_reg;
  // Mul: multiplicand magnitude. Div: divisor magnitude.
  logic [W-1:0]    opnd_reg;
  logic [W-1:0]    a_raw_reg;
  logic            neg_q_reg;
  logic            neg_r_reg;
  logic            div0_reg;
  logic            busy_reg;
  logic            done_reg;
  logic [W-1:0]    result_reg;

  // ---------------- operand preparation (at acceptance) ----------------
  logic          sign_a;
  logic          sign_b;
  logic [W-1:0]  a_mag;
  logic [W-1:0]  b_mag;
  logic          accept;

  always_comb begin
    sign_a = op_a_signed(funct3) & rs1_data[W-1];
    sign_b = op_b_signed(funct3) & rs2_data[W-1];
    a_mag  = sign_a ? (~rs1_data + 1'b1) : rs1_data;
    b_mag  = sign_b ? (~rs2_data + 1'b1) : rs2_data;
    accept = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
  end

  // ---------------- shared iteration datapath ----------------
  // A single adder serves both modes.
  // Mul: add the multiplicand when the multiplier LSB is 1.
  // Div: subtract the divisor (two's complement with carry-in);
  //      the top bit of the sum acts as the borrow.
  logic            is_div_op;
  logic [W:0]      addsub_x;
  logic [W+1:0]    addsub_y;
  logic [W+1:0]    addsub_sum;
  logic [2*W-1:0]  acc_next;

  always_comb begin
    is_div_op = op_is_div(op_reg);
    if (is_div_op) begin
      addsub_x = acc_reg[2*W-1:W-1];
      addsub_y = ~{2'b00, opnd_reg};
    end else begin
      addsub_x = {1'b0, acc_reg[2*W-1:W]};
      addsub_y = acc_reg[0] ? {2'b00, opnd_reg} : '0;
    end
    addsub_sum = {1'b0, addsub_x} + addsub_y + {{(W+1){1'b0}}, is_div_op};

    if (is_div_op) begin
      // Restoring step: keep the difference only if it did not borrow.
      if (addsub_sum[W+1]) acc_next = {acc_reg[2*W-2:0], 1'b0};
      else                 acc_next = {addsub_sum[W-1:0], acc_reg[W-2:0], 1'b1};
    end else begin
      acc_next = {addsub_sum[W:0], acc_reg[W-1:1]};
    end
  end

  // ---------------- sign correction / result select ----------------
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    quot_fix;
  logic [W-1:0]    rem_fix;
  logic [W-1:0]    final_val;

  always_comb begin
    prod_fix = neg_q_reg ? (~acc_reg + 1'b1) : acc_reg;
    quot_fix = neg_q_reg ? (~acc_reg[W-1:0] + 1'b1) : acc_reg[W-1:0];
    rem_fix  = neg_r_reg ? (~acc_reg[2*W-1:W] + 1'b1) : acc_reg[2*W-1:W];
    // Divide by zero: the iteration would yield an all-ones quotient
    // but a sign-flipped one for negative dividends, so both results are forced here.
    if (div0_reg) begin
      quot_fix = '1;
      rem_fix  = a_raw_reg;
    end
    case (op_reg)
      MULDIV_MUL:                           final_val = prod_fix[W-1:0];
      MULDIV_MULH, MULDIV_MULHSU,
      MULDIV_MULHU:                         final_val = prod_fix[2*W-1:W];
      MULDIV_DIV, MULDIV_DIVU:              final_val = quot_fix;
      default:                              final_val = rem_fix;
    endcase
  end

  // ---------------- FSM with registered outputs ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      count_reg  <= '0;
      op_reg     <= '0;
      acc_reg    <= '0;
      opnd_reg   <= '0;
      a_raw_reg  <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      div0_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
    end else if (kill) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          done_reg <= 1'b0;
        end
        S_BUSY: begin
          done_reg  <= 1'b0;
          acc_reg   <= acc_next;
          count_reg <= count_reg + 1'b1;  // wraps to 0 on the last step
          if (count_reg == CW'(W - 1)) state_reg <= S_DONE;
        end
        S_DONE: begin
          result_reg <= final_val;
          done_reg   <= 1'b1;
          busy_reg   <= 1'b0;
          state_reg  <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase

      // Acceptance from IDLE or DONE; in DONE this overrides the return to IDLE.
      if (accept) begin
        state_reg <= S_BUSY;
        busy_reg  <= 1'b1;
        count_reg <= '0;
        op_reg    <= funct3;
        a_raw_reg <= rs1_data;
        div0_reg  <= op_is_div(funct3) && (rs2_data == '0);
        if (op_is_div(funct3)) begin
          acc_reg   <= {{W{1'b0}}, a_mag};
          opnd_reg  <= b_mag;
          neg_q_reg <= sign_a ^ sign_b;
          neg_r_reg <= sign_a;
        end else begin
          acc_reg   <= {{W{1'b0}}, b_mag};
          opnd_reg  <= a_mag;
          neg_q_reg <= sign_a ^ sign_b;
          neg_r_reg <= 1'b0;
        end
      end
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign result = result_reg;

endmodule
